pwm_multichannel: RTL and testbench
===================================

// Module: pwm_multichannel
// PURPOSE
// - N-channel complementary PWM generator with programmable dead time per channel, one shared period counter.
// - Supports edge-aligned (sawtooth) and center-aligned (triangle) modes.
// - Configuration is double-buffered: it takes effect only at a period boundary.
// - Has a latched fault shutdown.
// - Drives gate drivers of multi-phase half bridges (e.g. 3-phase inverter); successor of the single-channel pwm block.
// PARAMETERS
// - bitwidth        8   width of counter, period, compare and deadtime values
// - channels        3   number of half-bridge channels (>=1)
// PORTS
// - clock                      in   1                  system clock
// - reset                      in   1                  asynchronous, active-low (0 = reset)
// - center_aligned             in   1                  0 = edge-aligned, 1 = center-aligned; shadowed
// - tick_count_period          in   bitwidth           period value P; shadowed
// - tick_count_compare         in   channels*bitwidth  per-channel duty compare C[i], channel i at [i*bitwidth +: bitwidth]
// - deadtime_hs_to_ls          in   channels*bitwidth  per-channel delay from highside off to lowside on
// - deadtime_ls_to_hs          in   channels*bitwidth  per-channel delay from lowside off to highside on
// - configuration_load_enable  in   1                  1 = copy inputs to active set at next load point
// - fault                      in   1                  synchronous fault request, level
// - fault_clear                in   1                  re-arm request after fault
// - highside                   out  channels           highside gate, active high
// - lowside                    out  channels           lowside gate, active high
// - period_start               out  1                  1-cycle pulse when counter restarts at 0
// - fault_latched              out  1                  1 while shutdown is active
// BEHAVIOUR
// Reset (async assert, sync release):
// - counter=0, direction=up, all active config regs=0, highside=lowside=0, period_start=0, fault_latched=0.
// Load point:
// - Active set (mode, P, C[], both deadtimes[]) loads from the inputs when configuration_load_enable=1 AND either
//   (a) the counter is in its last tick of the period, or (b) active P==0.
// - The new values govern the tick after loading. Inputs are never used directly.
// Counter, edge mode:
// - 0,1,..,P-1,0,...; period = P ticks.
// Counter, center mode:
// - Counts 0 up to P, then down to 1, then 0; period = 2P ticks.
// - Last tick is count 1 while counting down (P==1: sequence 0,1,0,1).
// Counter, both modes:
// - Active P==0 -> counter held at 0; all outputs low.
// - period_start is registered: high in the cycle the counter shows 0 after a wrap. It is not asserted while P==0.
// Reference signal:
// - ref[i] = (counter < C[i]), registered into ref_q[i].
// - C==0 -> never high. C>=P (edge) or C>P (center) -> always high; no dead-time gaps are inserted in that case.
// Dead time, per channel; outputs are registered:
// - ref_q rises at cycle t -> lowside falls at t+1, highside rises at t+1+Dls2hs.
// - ref_q falls at t -> highside falls at t+1, lowside rises at t+1+Dhs2ls.
// - D=0 -> complementary with no gap.
// - If ref_q reverts before the delay expires, the pending edge is cancelled: the pulse is swallowed and there is no glitch.
// - Invariant: highside[i] & lowside[i] is never 1 in any cycle, including across config loads.
// Fault:
// - fault=1 sampled -> next cycle all highside/lowside=0 and fault_latched=1.
// - The counter keeps running.
// - Clears only when fault_clear=1 and fault=0 in the same cycle.
// - After clearing, outputs stay low until the next period_start, then resume through the dead-time stage. Both delays restart from 0.
// - Simultaneous fault and fault_clear -> the fault wins.
// Reset mid-period:
// - Outputs go low immediately (async). Operation restarts with an all-zero active set, so the first load uses path (b).
// Widths:
// - All compares are unsigned at bitwidth.
// - Dead-time counters are bitwidth wide and saturate; they never wrap.
// STRUCTURE
// - Shared package/header: mode encoding (EDGE=0, CENTER=1) and helper localparams for bus slicing (channels*bitwidth).
// - Top module: shadow/active registers, period counter, up/down state, period_start, fault latch.
// - Sub-module pwm_deadtime, instantiated per channel via generate.
//   - Inputs: clock, reset, ref_q, two delays, force_off.
//   - Outputs: highside, lowside.
//   - Internal FSM: BOTH_OFF_TO_HS, HS_ON, BOTH_OFF_TO_LS, LS_ON, with one delay counter.
// TESTING
// 1. Edge mode, P=20, C0=7, Dhs2ls=3, Dls2hs=2, load=1, reset released at cycle 5:
//    -> period_start every 20 cycles; per period highside 5 cycles, gap 3, lowside 10, gap 2.
// 2. Center mode, P=10, C0=4, C1=0, C2=12, D=1/1:
//    -> period 20; ch0 symmetric pulse; ch1 lowside always on; ch2 highside always on; no overlap anywhere.
// 3. Mid-period change of C0 7->12 with load=1:
//    -> outputs follow the old value until the wrap; the new duty is visible from the next period_start.
//    With load=0 the change is never applied.
// 4. Dls2hs=9 with pulse width 5 -> highside never asserts; lowside drops for exactly the ref-high window plus Dhs2ls.
// 5. Fault asserted mid-pulse -> all outputs 0 the next cycle, fault_latched=1.
//    fault_clear with fault=1 -> stays latched. fault_clear with fault=0 -> outputs resume at the next period_start.
// 6. Reset asserted mid-pulse -> outputs 0 asynchronously. P=0 after reset -> counter stays 0 and no period_start.
//    Check the highside&lowside==0 assertion throughout all tests.

Source files
------------

// File: rtl/pwm_multichannel_pkg.sv
// Shared definitions for the multichannel complementary PWM generator.
//   pwm_mode_e   : counter shape, EDGE (sawtooth) or CENTER (triangle)
//   DEF_*        : default sizing and the width of a per-channel packed bus
package pwm_multichannel_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    localparam int unsigned DEF_BITWIDTH = 8;
    localparam int unsigned DEF_CHANNELS = 3;
    // Per-channel values are packed as channel i at [i*bitwidth +: bitwidth]
    localparam int unsigned DEF_BUS_W    = DEF_BITWIDTH * DEF_CHANNELS;

endpackage

// File: rtl/pwm_multichannel_if.sv
// Configuration / status bundle of the multichannel PWM generator.
//   master : configuration source (drives config, fault controls; reads gates and status)
//   slave  : the PWM block
interface pwm_multichannel_if #(
    parameter int unsigned bitwidth = 8,
    parameter int unsigned channels = 3
);
    localparam int unsigned BUS_W = bitwidth * channels;

    logic                center_aligned;
    logic [bitwidth-1:0] tick_count_period;
    logic [BUS_W-1:0]    tick_count_compare;
    logic [BUS_W-1:0]    deadtime_hs_to_ls;
    logic [BUS_W-1:0]    deadtime_ls_to_hs;
    logic                configuration_load_enable;
    logic                fault;
    logic                fault_clear;
    logic [channels-1:0] highside;
    logic [channels-1:0] lowside;
    logic                period_start;
    logic                fault_latched;

    modport master (
        output center_aligned, tick_count_period, tick_count_compare,
               deadtime_hs_to_ls, deadtime_ls_to_hs, configuration_load_enable,
               fault, fault_clear,
        input  highside, lowside, period_start, fault_latched
    );

    modport slave (
        input  center_aligned, tick_count_period, tick_count_compare,
               deadtime_hs_to_ls, deadtime_ls_to_hs, configuration_load_enable,
               fault, fault_clear,
        output highside, lowside, period_start, fault_latched
    );

endinterface

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time inserter: turns the registered reference into a
// non-overlapping highside/lowside pair.
//   clock, reset          : clock, async active-low reset
//   ref_i                 : registered PWM reference (1 = highside wanted)
//   dly_hs_to_ls_i        : ticks both off after highside turns off
//   dly_ls_to_hs_i        : ticks both off after lowside turns off
//   force_off_i           : drive both gates off and restart both delays
//   highside_o, lowside_o : registered gate drives
module pwm_deadtime #(
    parameter int unsigned bitwidth = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ref_i,
    input  logic [bitwidth-1:0] dly_hs_to_ls_i,
    input  logic [bitwidth-1:0] dly_ls_to_hs_i,
    input  logic                force_off_i,
    output logic                highside_o,
    output logic                lowside_o
);
    localparam logic [1:0] BOTH_OFF_TO_HS = 2'd0;
    localparam logic [1:0] HS_ON          = 2'd1;
    localparam logic [1:0] BOTH_OFF_TO_LS = 2'd2;
    localparam logic [1:0] LS_ON          = 2'd3;

    localparam logic [bitwidth-1:0] ONE = bitwidth'(1);

    logic [1:0]          state_q, state_d;
    logic [bitwidth-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic                hs_q, ls_q;

    // cnt_q holds how many ticks the reference has already been stable on the
    // side being waited for; it never wraps
    assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + ONE;

    // State register; gate outputs registered from the next state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= BOTH_OFF_TO_LS;
            cnt_q   <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hs_q    <= (state_d == HS_ON);
            ls_q    <= (state_d == LS_ON);
        end
    end

    // Next state; a reference reversal during a gap cancels the pending edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (force_off_i) begin
            state_d = BOTH_OFF_TO_LS;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HS_ON: begin
                    if (!ref_i) begin
                        if (dly_hs_to_ls_i == '0) begin
                            state_d = LS_ON;
                        end else begin
                            state_d = BOTH_OFF_TO_LS;
                            cnt_d   = ONE;
                        end
                    end
                end
                LS_ON: begin
                    if (ref_i) begin
                        if (dly_ls_to_hs_i == '0) begin
                            state_d = HS_ON;
                        end else begin
                            state_d = BOTH_OFF_TO_HS;
                            cnt_d   = ONE;
                        end
                    end
                end
                BOTH_OFF_TO_HS: begin
                    if (!ref_i) begin
                        if (dly_hs_to_ls_i == '0) begin
                            state_d = LS_ON;
                        end else begin
                            state_d = BOTH_OFF_TO_LS;
                            cnt_d   = ONE;
                        end
                    end else if (cnt_q >= dly_ls_to_hs_i) begin
                        state_d = HS_ON;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                default: begin
                    if (ref_i) begin
                        if (dly_ls_to_hs_i == '0) begin
                            state_d = HS_ON;
                        end else begin
                            state_d = BOTH_OFF_TO_HS;
                            cnt_d   = ONE;
                        end
                    end else if (cnt_q >= dly_hs_to_ls_i) begin
                        state_d = LS_ON;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
            endcase
        end
    end

    assign highside_o = hs_q;
    assign lowside_o  = ls_q;

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel complementary PWM generator with one shared period counter,
// edge/center alignment, double-buffered configuration and latched fault.
//   clock, reset : clock, async active-low reset
//   bus          : slave side of pwm_multichannel_if (config in, gates/status out)
module pwm_multichannel
    import pwm_multichannel_pkg::*;
#(
    parameter int unsigned bitwidth = 8,
    parameter int unsigned channels = 3
) (
    input logic              clock,
    input logic              reset,
    pwm_multichannel_if.slave bus
);
    localparam int unsigned         BUS_W = bitwidth * channels;
    localparam logic [bitwidth-1:0] ONE   = bitwidth'(1);

    pwm_mode_e           mode_q;
    logic [bitwidth-1:0] p_q;
    logic [BUS_W-1:0]    c_q, dhl_q, dlh_q;
    logic [bitwidth-1:0] cnt_q, cnt_d;
    logic                dir_q, dir_d;     // 1 = counting down (center mode)
    logic                ps_q, ps_d;
    logic                fault_q, fault_d;
    logic                blank_q, blank_d; // gates held off until a clean period start
    logic [channels-1:0] ref_q, ref_d;
    logic [channels-1:0] hs_w, ls_w;
    logic                last_tick_c, load_c, force_off_c;
    logic [bitwidth-1:0] p_next_c;

    // Last tick of the period: P-1 in edge mode, 1 on the way down in center
    // mode (with P==1 the count never goes down, so 1 itself is last)
    always_comb begin
        last_tick_c = 1'b0;
        if (p_q != '0) begin
            if (mode_q == MODE_EDGE) begin
                last_tick_c = (cnt_q == p_q - ONE);
            end else begin
                last_tick_c = (cnt_q == ONE) && (dir_q || (p_q == ONE));
            end
        end
    end

    assign load_c   = bus.configuration_load_enable && (last_tick_c || (p_q == '0));
    assign p_next_c = load_c ? bus.tick_count_period : p_q;

    // Period counter; every load point also restarts the count at 0 going up
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if ((p_q == '0) || last_tick_c) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (mode_q == MODE_EDGE) begin
            cnt_d = cnt_q + ONE;
        end else if (dir_q) begin
            cnt_d = cnt_q - ONE;
        end else if (cnt_q == p_q) begin
            cnt_d = cnt_q - ONE;
            dir_d = 1'b1;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Period start, fault latch and post-fault blanking
    always_comb begin
        ps_d    = last_tick_c && (p_next_c != '0);
        fault_d = fault_q;
        blank_d = blank_q;
        if (bus.fault) begin
            fault_d = 1'b1;
            blank_d = 1'b1;
        end else begin
            if (bus.fault_clear) begin
                fault_d = 1'b0;
            end
            if (ps_d && !fault_q) begin
                blank_d = 1'b0;
            end
        end
    end

    // Per-channel reference compare against the active compare values
    always_comb begin
        ref_d = '0;
        for (int i = 0; i < int'(channels); i++) begin
            ref_d[i] = (cnt_q < c_q[i*bitwidth +: bitwidth]);
        end
    end

    // Raw fault input is included so the gates drop on the edge that samples it
    assign force_off_c = bus.fault || blank_q || (p_q == '0);

    // Active configuration, counter and status registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q  <= MODE_EDGE;
            p_q     <= '0;
            c_q     <= '0;
            dhl_q   <= '0;
            dlh_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            ps_q    <= 1'b0;
            fault_q <= 1'b0;
            blank_q <= 1'b0;
            ref_q   <= '0;
        end else begin
            if (load_c) begin
                mode_q <= pwm_mode_e'(bus.center_aligned);
                p_q    <= bus.tick_count_period;
                c_q    <= bus.tick_count_compare;
                dhl_q  <= bus.deadtime_hs_to_ls;
                dlh_q  <= bus.deadtime_ls_to_hs;
            end
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ps_q    <= ps_d;
            fault_q <= fault_d;
            blank_q <= blank_d;
            ref_q   <= ref_d;
        end
    end

    // One dead-time stage per half bridge
    for (genvar g = 0; g < channels; g++) begin : g_ch
        pwm_deadtime #(
            .bitwidth(bitwidth)
        ) u_deadtime (
            .clock          (clock),
            .reset          (reset),
            .ref_i          (ref_q[g]),
            .dly_hs_to_ls_i (dhl_q[g*bitwidth +: bitwidth]),
            .dly_ls_to_hs_i (dlh_q[g*bitwidth +: bitwidth]),
            .force_off_i    (force_off_c),
            .highside_o     (hs_w[g]),
            .lowside_o      (ls_w[g])
        );
    end

    assign bus.highside      = hs_w;
    assign bus.lowside       = ls_w;
    assign bus.period_start  = ps_q;
    assign bus.fault_latched = fault_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: directed scenarios with literal expectations
// plus randomized configuration/fault traffic checked against a cycle model.
module tb_pwm_multichannel;
    localparam int unsigned BW = 8;
    localparam int unsigned CH = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pwm_multichannel_if #(.bitwidth(BW), .channels(CH)) bus_if ();

    pwm_multichannel #(.bitwidth(BW), .channels(CH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state (value valid during the cycle after each edge)
    bit m_mode;
    int m_p, m_phase;
    int m_c[CH], m_dhl[CH], m_dlh[CH];
    bit m_ps, m_fault, m_blank;
    bit m_ref[CH], m_hs[CH], m_ls[CH];
    int m_ones[CH], m_zeros[CH];

    int hs_cnt[CH], ls_cnt[CH], ps_cnt;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane(input logic [BW*CH-1:0] v, input int i);
        return int'(v[i*BW +: BW]);
    endfunction

    // Period position: phase runs 0..len-1; count is derived from it
    always @(posedge clock or negedge reset) begin
        int  len, cnt, nphase;
        bit  last, load, forced;
        if (!reset) begin
            m_mode = 0; m_p = 0; m_phase = 0; m_ps = 0; m_fault = 0; m_blank = 0;
            for (int i = 0; i < CH; i++) begin
                m_c[i] = 0; m_dhl[i] = 0; m_dlh[i] = 0;
                m_ref[i] = 0; m_hs[i] = 0; m_ls[i] = 0; m_ones[i] = 0; m_zeros[i] = 0;
            end
        end else begin
            len    = m_mode ? 2 * m_p : m_p;
            cnt    = (m_mode && m_phase > m_p) ? 2 * m_p - m_phase : m_phase;
            last   = (m_p != 0) && (m_phase == len - 1);
            load   = bus_if.configuration_load_enable && (last || m_p == 0);
            forced = bus_if.fault || m_blank || (m_p == 0);
            for (int i = 0; i < CH; i++) begin
                // a gate turns on once the reference has held its level for delay+1 ticks
                if (forced) begin
                    m_hs[i] = 0; m_ls[i] = 0; m_ones[i] = 0; m_zeros[i] = 0;
                end else if (m_ref[i]) begin
                    m_hs[i] = m_hs[i] || (m_ones[i] >= m_dlh[i]);
                    m_ls[i] = 0;
                    m_ones[i]++;
                    m_zeros[i] = 0;
                end else begin
                    m_ls[i] = m_ls[i] || (m_zeros[i] >= m_dhl[i]);
                    m_hs[i] = 0;
                    m_zeros[i]++;
                    m_ones[i] = 0;
                end
                m_ref[i] = (cnt < m_c[i]);
            end
            nphase = (last || m_p == 0) ? 0 : m_phase + 1;
            if (load) begin
                m_mode = bus_if.center_aligned;
                m_p    = int'(bus_if.tick_count_period);
                for (int i = 0; i < CH; i++) begin
                    m_c[i]   = lane(bus_if.tick_count_compare, i);
                    m_dhl[i] = lane(bus_if.deadtime_hs_to_ls, i);
                    m_dlh[i] = lane(bus_if.deadtime_ls_to_hs, i);
                end
            end
            m_phase = nphase;
            m_ps    = last && (m_p != 0);
            if (bus_if.fault) m_blank = 1;
            else if (m_ps && !m_fault) m_blank = 0;
            if (bus_if.fault) m_fault = 1;
            else if (bus_if.fault_clear) m_fault = 0;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        logic [CH-1:0] eh, el;
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                eh[i] = m_hs[i];
                el[i] = m_ls[i];
            end
            check("highside", int'(bus_if.highside), int'(eh));
            check("lowside", int'(bus_if.lowside), int'(el));
            check("period_start", int'(bus_if.period_start), int'(m_ps));
            check("fault_latched", int'(bus_if.fault_latched), int'(m_fault));
            check("overlap", int'(bus_if.highside & bus_if.lowside), 0);
        end
    end

    task automatic set_ch(input int i, input int c, input int dhl, input int dlh);
        bus_if.tick_count_compare[i*BW +: BW] = BW'(c);
        bus_if.deadtime_hs_to_ls[i*BW +: BW]  = BW'(dhl);
        bus_if.deadtime_ls_to_hs[i*BW +: BW]  = BW'(dlh);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic measure(input int n);
        ps_cnt = 0;
        for (int i = 0; i < CH; i++) begin
            hs_cnt[i] = 0;
            ls_cnt[i] = 0;
        end
        repeat (n) begin
            @(negedge clock);
            #1;
            ps_cnt += int'(bus_if.period_start);
            for (int i = 0; i < CH; i++) begin
                hs_cnt[i] += int'(bus_if.highside[i]);
                ls_cnt[i] += int'(bus_if.lowside[i]);
            end
        end
    endtask

    task automatic wait_hs0();
        int k = 0;
        while (bus_if.highside[0] !== 1'b1 && k < 100) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("wait_hs0_timeout", int'(k < 100), 1);
    endtask

    task automatic wait_ps();
        int k = 0;
        while (bus_if.period_start !== 1'b1 && k < 100) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("wait_ps_timeout", int'(k < 100), 1);
    endtask

    initial begin
        bus_if.center_aligned            = 1'b0;
        bus_if.tick_count_period         = '0;
        bus_if.tick_count_compare        = '0;
        bus_if.deadtime_hs_to_ls         = '0;
        bus_if.deadtime_ls_to_hs         = '0;
        bus_if.configuration_load_enable = 1'b0;
        bus_if.fault                     = 1'b0;
        bus_if.fault_clear               = 1'b0;

        // Reset state
        cycles(2);
        check("rst_highside", int'(bus_if.highside), 0);
        check("rst_lowside", int'(bus_if.lowside), 0);
        check("rst_period_start", int'(bus_if.period_start), 0);
        check("rst_fault_latched", int'(bus_if.fault_latched), 0);

        // Edge mode P=20, C0=7, 3/2 dead time; release at cycle 5
        bus_if.tick_count_period = 8'd20;
        set_ch(0, 7, 3, 2);
        set_ch(1, 0, 0, 0);
        set_ch(2, 25, 0, 0);
        bus_if.configuration_load_enable = 1'b1;
        cycles(3);
        reset = 1'b1;
        cycles(60);
        measure(20);
        check("t1_hs0", hs_cnt[0], 5);
        check("t1_ls0", ls_cnt[0], 10);
        check("t1_ls1", ls_cnt[1], 20);
        check("t1_hs2", hs_cnt[2], 20);
        measure(40);
        check("t1_ps40", ps_cnt, 2);

        // Center mode P=10, C={4,0,12}, dead time 1/1
        bus_if.center_aligned    = 1'b1;
        bus_if.tick_count_period = 8'd10;
        set_ch(0, 4, 1, 1);
        set_ch(1, 0, 1, 1);
        set_ch(2, 12, 1, 1);
        cycles(60);
        measure(20);
        check("t2_hs0", hs_cnt[0], 6);
        check("t2_ls0", ls_cnt[0], 12);
        check("t2_ls1", ls_cnt[1], 20);
        check("t2_hs1", hs_cnt[1], 0);
        check("t2_hs2", hs_cnt[2], 20);
        check("t2_ls2", ls_cnt[2], 0);
        check("t2_ps", ps_cnt, 1);

        // Compare change 7->12: ignored with load=0, applied with load=1
        bus_if.center_aligned    = 1'b0;
        bus_if.tick_count_period = 8'd20;
        set_ch(0, 7, 3, 2);
        cycles(60);
        wait_ps();
        cycles(9);
        bus_if.configuration_load_enable = 1'b0;
        set_ch(0, 12, 3, 2);
        cycles(60);
        measure(20);
        check("t3_hold_hs0", hs_cnt[0], 5);
        bus_if.configuration_load_enable = 1'b1;
        cycles(50);
        measure(20);
        check("t3_new_hs0", hs_cnt[0], 10);
        check("t3_new_ls0", ls_cnt[0], 5);

        // Pulse narrower than the lowside-to-highside delay is swallowed
        set_ch(0, 5, 3, 9);
        cycles(60);
        measure(20);
        check("t4_hs0", hs_cnt[0], 0);
        check("t4_ls0", ls_cnt[0], 12);

        // Fault mid-pulse, clear attempts, resume
        set_ch(0, 7, 3, 2);
        cycles(60);
        wait_hs0();
        bus_if.fault = 1'b1;
        cycles(1);
        check("t5_fault_hs", int'(bus_if.highside), 0);
        check("t5_fault_ls", int'(bus_if.lowside), 0);
        check("t5_fault_latched", int'(bus_if.fault_latched), 1);
        bus_if.fault_clear = 1'b1;
        cycles(2);
        check("t5_clear_with_fault", int'(bus_if.fault_latched), 1);
        bus_if.fault = 1'b0;
        cycles(1);
        bus_if.fault_clear = 1'b0;
        check("t5_cleared", int'(bus_if.fault_latched), 0);
        check("t5_still_off", int'(bus_if.highside | bus_if.lowside), 0);
        wait_ps();
        cycles(40);
        measure(20);
        check("t5_resume_hs0", hs_cnt[0], 5);

        // Randomized configuration, load and fault traffic
        repeat (2500) begin
            if ($urandom_range(0, 7) == 0) begin
                bus_if.center_aligned    = 1'($urandom_range(0, 1));
                bus_if.tick_count_period = BW'($urandom_range(0, 12));
                for (int i = 0; i < CH; i++) begin
                    set_ch(i, int'($urandom_range(0, 14)), int'($urandom_range(0, 9)),
                           int'($urandom_range(0, 9)));
                end
            end
            bus_if.configuration_load_enable = ($urandom_range(0, 3) == 0);
            bus_if.fault       = ($urandom_range(0, 79) == 0);
            bus_if.fault_clear = ($urandom_range(0, 7) == 0);
            cycles(1);
        end
        bus_if.fault       = 1'b0;
        bus_if.fault_clear = 1'b1;
        cycles(1);
        bus_if.fault_clear = 1'b0;

        // Asynchronous reset mid-pulse, then P=0 keeps everything idle
        bus_if.center_aligned            = 1'b0;
        bus_if.tick_count_period         = 8'd20;
        set_ch(0, 7, 3, 2);
        bus_if.configuration_load_enable = 1'b1;
        cycles(60);
        wait_hs0();
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_hs", int'(bus_if.highside), 0);
        check("t6_async_ls", int'(bus_if.lowside), 0);
        bus_if.tick_count_period = 8'd0;
        cycles(1);
        reset = 1'b1;
        measure(30);
        check("t6_p0_ps", ps_cnt, 0);
        check("t6_p0_hs0", hs_cnt[0], 0);
        check("t6_p0_ls0", ls_cnt[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
